reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..8).
REQ-002 Parameter W, default 8: width of the shared register.
REQ-003 C  input  1  clock; all state changes on rising edge.
REQ-004 R  input  1  reset; asynchronous, active-low (R=0 resets immediately, independent of C).
REQ-005 req  input  NREQ  per-requester write request, level; bit i = requester i.
REQ-006 wdata  input  NREQ*W  write data; requester i owns bits [i*W +: W].
REQ-007 gnt  output  NREQ  one-hot grant; high for exactly the WRITE cycle.
REQ-008 ack  output  NREQ  one-hot completion pulse; high for exactly the DONE cycle.
REQ-009 q  output  W  shared register contents.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 wcount  output  8  count of completed writes, modulo 256.

Function
REQ-012 FSM states: IDLE, WRITE, DONE; encoding 2 bits, IDLE=00, WRITE=01, DONE=10; 11 unreachable, recovers to IDLE on next edge.
REQ-013 IDLE: req==0 -> stay IDLE, all outputs hold.
REQ-014 IDLE, req!=0: at edge select winner w = first set bit scanning ptr, ptr+1, ... mod NREQ; gnt<=onehot(w); state<=WRITE.
REQ-015 WRITE: at edge q<=wdata[w] (value sampled at that edge); gnt<=0; ack<=onehot(w); wcount<=wcount+1; ptr<=(w+1) mod NREQ; state<=DONE.
REQ-016 DONE: at edge ack<=0; state<=IDLE; req ignored during DONE.
REQ-017 req sampled only in IDLE; dropping req[w] during WRITE or DONE does not abort or alter the write.
REQ-018 Transaction latency: req seen at edge k -> gnt high k..k+1, q updated and ack high k+1..k+2, IDLE at k+2.
REQ-019 Throughput: max one write per 3 cycles; requester still asserting req in IDLE after its ack is treated as a new request.
REQ-020 Round-robin fairness: with all req high, grant order is ptr, ptr+1, ... ; no requester waits more than NREQ-1 transactions.
REQ-021 wcount wraps 255 -> 0 with no flag.
REQ-022 gnt and ack never both nonzero; each at most one bit set.
REQ-023 busy = (state != IDLE), combinational from state register.
REQ-024 wdata of non-winning requesters never affects q.

Reset
REQ-025 R=0 forces state=IDLE, gnt=0, ack=0, q=0, wcount=0, ptr=0, busy=0 asynchronously.
REQ-026 Reset asserted during WRITE or DONE aborts the transaction; q is 0, no ack is issued after release.
REQ-027 After R rises, first arbitration occurs at the first rising C edge with R=1 and req!=0.

Structure
REQ-028 Shared package holds state encodings (IDLE/WRITE/DONE), default NREQ and W, and wcount width 8.
REQ-029 Sub-module rr_pick (combinational): inputs req, ptr; outputs one-hot winner and winner index; instantiated once.
REQ-030 All flops in the block are reset-to-0 flops with active-low async reset; no latches.

Verification
REQ-031 R=0 mid-WRITE (req=0001, wdata0=8'hA5) -> q=0, gnt=0, ack=0, wcount=0 immediately; no ack after R=1.
REQ-032 Single req=0100, wdata2=8'h3C -> gnt=0100 one cycle, then ack=0100 one cycle and q=8'h3C, wcount=1, busy high 2 cycles.
REQ-033 req=1111 held, wdata_i=8'h10+i -> grant order 0,1,2,3,0; q sequence 10,11,12,13,10; gap of 3 cycles between grants.
REQ-034 req[1] dropped during WRITE (wdata1=8'h77) -> q=8'h77, ack=0010 still issued.
REQ-035 req changed from 0001 to 1000 during DONE -> ignored in DONE; next IDLE grants 1000.
REQ-036 256 writes from requester 0 -> wcount returns to 0, q equals last wdata0.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the round-robin register write arbiter:
// FSM encodings, default sizing and the completed-write counter width.
package reg_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 8;
    localparam int WCOUNT_W = 8;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning from ptr
// upward with wrap, returned both as an index and as a one-hot vector.
module rr_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_onehot,
    output logic [PW-1:0]   win_idx
);

    // Scan from the farthest offset down so the nearest set bit to ptr wins last.
    always_comb begin
        int cand_s;
        cand_s     = 0;
        win_idx    = '0;
        win_onehot = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_s  = (int'(ptr) + k) % NREQ;
            win_idx = req[cand_s] ? PW'(cand_s) : win_idx;
        end
        win_onehot[win_idx] = |req;
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared
// W-bit register, one IDLE -> WRITE -> DONE transaction at a time.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) (
    input  logic                C,
    input  logic                R,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     ack,
    output logic [W-1:0]        q,
    output logic                busy,
    output logic [WCOUNT_W-1:0] wcount
);

    localparam int PW = $clog2(NREQ);

    state_t              state_r;
    logic [NREQ-1:0]     gnt_r;
    logic [NREQ-1:0]     ack_r;
    logic [W-1:0]        q_r;
    logic [WCOUNT_W-1:0] wcount_r;
    logic [PW-1:0]       ptr_r;
    logic [PW-1:0]       win_idx_r;
    logic [NREQ-1:0]     pick_onehot_s;
    logic [PW-1:0]       pick_idx_s;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req        (req),
        .ptr        (ptr_r),
        .win_onehot (pick_onehot_s),
        .win_idx    (pick_idx_s)
    );

    // Transaction FSM; the winner index is latched at grant so later req/wdata
    // changes of other requesters cannot redirect the write.
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_r   <= ST_IDLE;
            gnt_r     <= '0;
            ack_r     <= '0;
            q_r       <= '0;
            wcount_r  <= '0;
            ptr_r     <= '0;
            win_idx_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_r     <= pick_onehot_s;
                        win_idx_r <= pick_idx_s;
                        state_r   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    q_r      <= wdata[int'(win_idx_r)*W +: W];
                    gnt_r    <= '0;
                    ack_r    <= gnt_r;
                    wcount_r <= wcount_r + WCOUNT_W'(1);
                    ptr_r    <= (win_idx_r == PW'(NREQ - 1)) ? '0 : win_idx_r + PW'(1);
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    ack_r   <= '0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    gnt_r   <= '0;
                    ack_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_r != ST_IDLE);
    assign gnt    = gnt_r;
    assign ack    = ack_r;
    assign q      = q_r;
    assign wcount = wcount_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (NREQ=4, W=8) with hand-computed expectations.
module tb_reg_write_arbiter;

    logic        C;
    logic        R;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        busy;
    logic [7:0]  wcount;

    int errors = 0;
    int checks = 0;

    reg_write_arbiter #(.NREQ(4), .W(8)) dut (
        .C      (C),
        .R      (R),
        .req    (req),
        .wdata  (wdata),
        .gnt    (gnt),
        .ack    (ack),
        .q      (q),
        .busy   (busy),
        .wcount (wcount)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic do_reset();
        R = 1'b0;
        #13;
        R = 1'b1;
        tick();
    endtask

    initial begin
        R = 1'b1;
        req = 4'b0000;
        wdata = 32'h0000_0000;
        #2;
        R = 1'b0;
        #1;
        check("rst_gnt", {28'd0, gnt}, 32'h0);
        check("rst_ack", {28'd0, ack}, 32'h0);
        check("rst_q", {24'd0, q}, 32'h0);
        check("rst_wcount", {24'd0, wcount}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        #10;
        R = 1'b1;
        tick();
        tick();
        check("idle_hold_busy", {31'd0, busy}, 32'h0);
        check("idle_hold_gnt", {28'd0, gnt}, 32'h0);

        // Single request from requester 2
        req = 4'b0100;
        wdata = 32'h003C_0000;
        tick();
        check("single_gnt", {28'd0, gnt}, 32'h4);
        check("single_ack0", {28'd0, ack}, 32'h0);
        check("single_busy0", {31'd0, busy}, 32'h1);
        tick();
        req = 4'b0000;
        check("single_gnt_off", {28'd0, gnt}, 32'h0);
        check("single_ack", {28'd0, ack}, 32'h4);
        check("single_q", {24'd0, q}, 32'h3C);
        check("single_wcount", {24'd0, wcount}, 32'h1);
        check("single_busy1", {31'd0, busy}, 32'h1);
        tick();
        check("single_ack_off", {28'd0, ack}, 32'h0);
        check("single_busy2", {31'd0, busy}, 32'h0);

        // All requesting: round-robin from ptr=0
        do_reset();
        req = 4'b1111;
        wdata = 32'h1312_1110;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rr_gnt%0d", i), {28'd0, gnt}, 32'h1 << (i % 4));
            check($sformatf("rr_ack_off%0d", i), {28'd0, ack}, 32'h0);
            tick();
            check($sformatf("rr_ack%0d", i), {28'd0, ack}, 32'h1 << (i % 4));
            check($sformatf("rr_q%0d", i), {24'd0, q}, 32'h10 + (i % 4));
            check($sformatf("rr_nogap%0d", i), {28'd0, gnt}, 32'h0);
            tick();
            check($sformatf("rr_idle%0d", i), {31'd0, busy}, 32'h0);
        end
        check("rr_wcount", {24'd0, wcount}, 32'h5);

        // Requester 1 drops req during WRITE (ptr is now 1)
        req = 4'b0010;
        wdata = 32'hEEEE_77EE;
        tick();
        check("drop_gnt", {28'd0, gnt}, 32'h2);
        req = 4'b0000;
        tick();
        check("drop_ack", {28'd0, ack}, 32'h2);
        check("drop_q", {24'd0, q}, 32'h77);
        tick();
        check("drop_wcount", {24'd0, wcount}, 32'h6);

        // req switches 0001 -> 1000 during DONE (ptr is now 2)
        req = 4'b0001;
        wdata = 32'hC300_005A;
        tick();
        check("done_gnt0", {28'd0, gnt}, 32'h1);
        tick();
        check("done_q0", {24'd0, q}, 32'h5A);
        check("done_ack0", {28'd0, ack}, 32'h1);
        req = 4'b1000;
        tick();
        check("done_ignored_gnt", {28'd0, gnt}, 32'h0);
        check("done_ignored_busy", {31'd0, busy}, 32'h0);
        tick();
        check("done_gnt3", {28'd0, gnt}, 32'h8);
        req = 4'b0000;
        tick();
        check("done_q3", {24'd0, q}, 32'hC3);
        check("done_ack3", {28'd0, ack}, 32'h8);
        tick();
        check("done_wcount", {24'd0, wcount}, 32'h8);

        // Reset asserted mid-WRITE (ptr is now 0)
        req = 4'b0001;
        wdata = 32'h0000_00A5;
        tick();
        check("abort_gnt_pre", {28'd0, gnt}, 32'h1);
        #2;
        R = 1'b0;
        #1;
        check("abort_q", {24'd0, q}, 32'h0);
        check("abort_gnt", {28'd0, gnt}, 32'h0);
        check("abort_ack", {28'd0, ack}, 32'h0);
        check("abort_wcount", {24'd0, wcount}, 32'h0);
        check("abort_busy", {31'd0, busy}, 32'h0);
        req = 4'b0000;
        #3;
        R = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort_noack%0d", i), {28'd0, ack}, 32'h0);
            check($sformatf("abort_q_hold%0d", i), {24'd0, q}, 32'h0);
        end
        req = 4'b0100;
        wdata = 32'h0099_0000;
        tick();
        check("post_rst_gnt", {28'd0, gnt}, 32'h4);
        req = 4'b0000;
        tick();
        check("post_rst_q", {24'd0, q}, 32'h99);
        tick();

        // 256 writes from requester 0: wcount wraps to 0
        do_reset();
        for (int i = 0; i < 256; i++) begin
            req = 4'b0001;
            wdata = {24'd0, 8'(i) ^ 8'h5A};
            tick();
            req = 4'b0000;
            tick();
            tick();
            if (i == 254) check("wrap_255", {24'd0, wcount}, 32'hFF);
        end
        check("wrap_wcount", {24'd0, wcount}, 32'h0);
        check("wrap_q", {24'd0, q}, 32'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
